// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic-light controller.
//   state_t     : phase encoding, also exported on the debug/LED port.
//   C_MS_CYCLES : clk cycles per millisecond at the default clock rate.
//   ms_cycles() : the same figure for any clock rate.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  localparam int C_CLK_FRQ_DEF = 100_000_000;
  localparam int C_MS_CYCLES   = C_CLK_FRQ_DEF / 1000;

  function automatic int ms_cycles(input int clk_frq);
    return clk_frq / 1000;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: millisecond timer made of a clock prescaler and a ms counter.
//   clk        : clock
//   rstb       : synchronous active-low reset
//   clr        : synchronous clear of both counters (e.g. on a phase change)
//   tick       : high in the last cycle of each millisecond
//   elapsed_ms : whole milliseconds since the last clear/reset
module ms_timer #(
  parameter int C_MS_CYCLES = 100_000,
  parameter int C_MS_W      = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              clr,
  output logic              tick,
  output logic [C_MS_W-1:0] elapsed_ms
);

  localparam int PW = (C_MS_CYCLES > 1) ? $clog2(C_MS_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(C_MS_CYCLES - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rstb || clr) begin
      presc      <= '0;
      elapsed_ms <= '0;
    end else if (tick) begin
      presc <= '0;
      // Saturate so an untimed phase (e.g. flashing) can sit forever.
      if (elapsed_ms != '1)
        elapsed_ms <= elapsed_ms + C_MS_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: RED -> GREEN -> YELLOW -> RED phase sequencer with
// pedestrian-shortened GREEN and a night (flashing yellow) mode.
//   clk, rstb : clock, synchronous active-low reset
//   blink     : blinker square wave, passed to yellow while flashing
//   night     : level, requests flashing-yellow night mode
//   ped_req   : pedestrian request (pulse or level)
//   red/yellow/green/walk : lamp drives (Moore decode of the state)
//   state     : current phase encoding for debug LEDs
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int C_CLK_FRQ      = 100_000_000,
  parameter int C_RED_MS       = 4000,
  parameter int C_GREEN_MS     = 5000,
  parameter int C_GREEN_MIN_MS = 2000,
  parameter int C_YELLOW_MS    = 1000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       blink,
  input  logic       night,
  input  logic       ped_req,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       walk,
  output logic [1:0] state
);

  localparam int C_MSC   = ms_cycles(C_CLK_FRQ);
  localparam int C_MAX_A = (C_RED_MS > C_GREEN_MS) ? C_RED_MS : C_GREEN_MS;
  localparam int C_MAX   = (C_MAX_A > C_YELLOW_MS) ? C_MAX_A : C_YELLOW_MS;
  localparam int C_MS_W  = $clog2(C_MAX) + 1;

  localparam logic [C_MS_W-1:0] RED_MS  = C_MS_W'(C_RED_MS);
  localparam logic [C_MS_W-1:0] GRN_MS  = C_MS_W'(C_GREEN_MS);
  localparam logic [C_MS_W-1:0] GMIN_MS = C_MS_W'(C_GREEN_MIN_MS);
  localparam logic [C_MS_W-1:0] YEL_MS  = C_MS_W'(C_YELLOW_MS);

  state_t            st, st_nxt;
  logic              pending, pending_nxt;
  logic              tick, clr;
  logic [C_MS_W-1:0] elapsed, el_nxt;

  ms_timer #(
    .C_MS_CYCLES (C_MSC),
    .C_MS_W      (C_MS_W)
  ) u_tmr (
    .clk        (clk),
    .rstb       (rstb),
    .clr        (clr),
    .tick       (tick),
    .elapsed_ms (elapsed)
  );

  // Millisecond count the counter reaches at the coming edge. Comparing on
  // this value lets an N ms phase end on exactly its N*C_MSC-th edge.
  assign el_nxt = elapsed + C_MS_W'(tick);
  assign clr    = (st_nxt != st);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      st      <= S_RED;
      pending <= 1'b0;
    end else begin
      st      <= st_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_RED: begin
        if (night)                st_nxt = S_FLASH;
        else if (el_nxt == RED_MS) st_nxt = S_GREEN;
      end
      S_GREEN: begin
        if (night || (pending && el_nxt >= GMIN_MS) || el_nxt == GRN_MS)
          st_nxt = S_YELLOW;
      end
      S_YELLOW: begin
        if (el_nxt == YEL_MS) st_nxt = night ? S_FLASH : S_RED;
      end
      S_FLASH: begin
        if (!night) st_nxt = S_RED;
      end
      default: st_nxt = S_RED;
    endcase

    // Requests only latch in GREEN/YELLOW; entering RED serves them, and the
    // clear takes priority over a request on that same cycle.
    pending_nxt = pending | (ped_req & (st == S_GREEN || st == S_YELLOW));
    if (st_nxt == S_RED || st_nxt == S_FLASH)
      pending_nxt = 1'b0;
  end

  assign red    = (st == S_RED);
  assign walk   = (st == S_RED);
  assign green  = (st == S_GREEN);
  assign yellow = (st == S_YELLOW) | ((st == S_FLASH) & blink);
  assign state  = st;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl at 10 clk cycles per ms.
// A cycle-count reference model predicts the lamps each cycle; directed
// sequences cover the phase lengths and corner cases, then random stimulus.
module tb_traffic_light_ctrl;

  localparam int P      = 10;
  localparam int RED_MS = 4;
  localparam int GRN_MS = 5;
  localparam int MIN_MS = 2;
  localparam int YEL_MS = 2;
  localparam int M_RED  = 0;
  localparam int M_GRN  = 1;
  localparam int M_YEL  = 2;
  localparam int M_FLS  = 3;

  logic clk = 1'b0, rstb = 1'b0, blink = 1'b0, night = 1'b0, ped_req = 1'b0;
  logic red, yellow, green, walk;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase, cycles spent in it, pending request.
  int m_st  = M_RED;
  int m_cyc = 0;
  bit m_pend = 1'b0;

  traffic_light_ctrl #(
    .C_CLK_FRQ      (P * 1000),
    .C_RED_MS       (RED_MS),
    .C_GREEN_MS     (GRN_MS),
    .C_GREEN_MIN_MS (MIN_MS),
    .C_YELLOW_MS    (YEL_MS)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .blink   (blink),
    .night   (night),
    .ped_req (ped_req),
    .red     (red),
    .yellow  (yellow),
    .green   (green),
    .walk    (walk),
    .state   (state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (7) @(negedge clk);
      blink = ~blink;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_out();
    return {2'(m_st), m_st == M_RED, (m_st == M_YEL) || (m_st == M_FLS && blink),
            m_st == M_GRN, m_st == M_RED};
  endfunction

  // Phase rules expressed in whole cycles: an N ms phase ends after N*P edges.
  task automatic model_step(input bit p, input bit n, input bit rb);
    int nx;
    if (!rb) begin
      m_st = M_RED; m_cyc = 0; m_pend = 1'b0;
      return;
    end
    nx = m_st;
    case (m_st)
      M_RED: if (n) nx = M_FLS; else if (m_cyc + 1 == RED_MS * P) nx = M_GRN;
      M_GRN: if (n || (m_pend && m_cyc + 1 >= MIN_MS * P) || m_cyc + 1 == GRN_MS * P)
               nx = M_YEL;
      M_YEL: if (m_cyc + 1 == YEL_MS * P) nx = n ? M_FLS : M_RED;
      default: if (!n) nx = M_RED;
    endcase
    if (nx == M_RED || nx == M_FLS) m_pend = 1'b0;
    else m_pend = m_pend || (p && (m_st == M_GRN || m_st == M_YEL));
    m_cyc = (nx != m_st) ? 0 : m_cyc + 1;
    m_st  = nx;
  endtask

  // One clock: apply ped_req/rstb (night as currently set), check after the
  // edge and again after the falling edge where blink may have toggled.
  task automatic cyc(input bit p, input bit rb);
    ped_req = p;
    rstb    = rb;
    @(posedge clk);
    model_step(p, night, rb);
    #1;
    chk("lamps_pos", {state, red, yellow, green, walk}, exp_out());
    chk("red_green_excl", red & green, 0);
    @(negedge clk);
    #1;
    chk("lamps_neg", {state, red, yellow, green, walk}, exp_out());
  endtask

  // Count cycles the DUT stays in phase st (bounded), compare with exp.
  task automatic hold_len(input string tag, input int st, input int exp);
    int cnt = 0;
    while (state == 2'(st) && cnt < 200) begin
      cnt++;
      cyc(1'b0, 1'b1);
    end
    chk(tag, cnt, exp);
  endtask

  initial begin
    // Reset and idle sequence
    repeat (3) cyc(1'b0, 1'b0);
    chk("reset_state", state, M_RED);
    chk("reset_lamps", {red, yellow, green, walk}, 4'b1001);
    hold_len("idle_red", M_RED, 40);
    hold_len("idle_green", M_GRN, 50);
    hold_len("idle_yellow", M_YEL, 20);
    hold_len("idle_red2", M_RED, 40);

    // Early request shortens GREEN to the minimum
    repeat (5) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    hold_len("ped_early_green", M_GRN, 14);
    hold_len("ped_early_yellow", M_YEL, 20);
    hold_len("ped_served_red", M_RED, 40);

    // Late request: latch edge, then transition edge
    repeat (30) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("ped_late_latch", state, M_GRN);
    cyc(1'b0, 1'b1);
    chk("ped_late_exit", state, M_YEL);
    hold_len("ped_late_yellow", M_YEL, 20);

    // Request during RED is ignored
    repeat (5) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    hold_len("ped_red_ignored", M_RED, 34);
    hold_len("green_full", M_GRN, 50);
    hold_len("yellow_b", M_YEL, 20);
    hold_len("red_b", M_RED, 40);

    // Night during GREEN: full YELLOW then flashing
    repeat (10) cyc(1'b0, 1'b1);
    night = 1'b1;
    cyc(1'b0, 1'b1);
    chk("night_green_exit", state, M_YEL);
    hold_len("night_yellow", M_YEL, 20);
    repeat (40) cyc(1'b0, 1'b1);
    chk("flash_hold", state, M_FLS);

    // Leaving night gives a full RED
    night = 1'b0;
    cyc(1'b0, 1'b1);
    chk("flash_exit", state, M_RED);
    hold_len("post_flash_red", M_RED, 40);
    hold_len("green_c", M_GRN, 50);
    hold_len("yellow_c", M_YEL, 20);

    // Night during RED goes to flashing at once
    repeat (3) cyc(1'b0, 1'b1);
    night = 1'b1;
    cyc(1'b0, 1'b1);
    chk("night_red", state, M_FLS);
    night = 1'b0;
    cyc(1'b0, 1'b1);
    hold_len("red_d", M_RED, 40);

    // Reset in GREEN with a pending request
    repeat (24) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("midreset_state", state, M_RED);
    hold_len("midreset_red", M_RED, 40);
    hold_len("midreset_green", M_GRN, 50);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(149) == 0) night = ~night;
      cyc($urandom_range(39) == 0, $urandom_range(499) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
